// File: rtl/cmos_pkg.sv
// Shared types and widths for the OV5640 DVP capture path.
package cmos_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FRAME = 2'd1,
    S_LINE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // The sensor sends the high byte first, so the pair maps straight onto {R,G,B}.
  function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    rgb565_t p;
    p.r = hi[7:3];
    p.g = {hi[2:0], lo[7:5]};
    p.b = lo[4:0];
    return p;
  endfunction

endpackage

// File: rtl/ov5640_capture_if.sv
// Pixel write bus from the capture stage into the frame-buffer write FIFO.
interface ov5640_capture_if;
  import cmos_pkg::*;

  logic             pix_valid;
  logic [15:0]      pix_data;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic             pix_sof;
  logic             pix_eol;
  logic             fifo_full;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    input  fifo_full
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    output fifo_full
  );

endinterface

// File: rtl/cmos_in_reg.sv
// Input stage: registers the DVP bus once and normalises VSYNC to active-high.
module cmos_in_reg #(
  parameter bit VSYNC_ACT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] db_i,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] db_o
);

  logic       vsync_q;
  logic       href_q;
  logic [7:0] db_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Reset to "inside frame" so releasing reset mid-frame cannot fake a frame start.
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
      db_q    <= 8'h00;
    end else begin
      vsync_q <= (vsync_i == VSYNC_ACT);
      href_q  <= href_i;
      db_q    <= db_i;
    end
  end

  assign vsync_o = vsync_q;
  assign href_o  = href_q;
  assign db_o    = db_q;

endmodule

// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: frame lock, byte pairing to RGB565, window crop and tagged FIFO writes.
module ov5640_capture
  import cmos_pkg::*;
#(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter bit          VSYNC_ACT = 1'b1
) (
  input  logic             CMOS_PCLK,
  input  logic             cmos_rst,
  input  logic             CMOS_VSYNC,
  input  logic             CMOS_HREF,
  input  logic [7:0]       CMOS_DB,
  input  logic             capture_en,
  input  logic             err_clr,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic             overflow,
  output logic             line_err,
  ov5640_capture_if.master pix_bus
);

  logic       vs, href;
  logic [7:0] db;

  cmos_in_reg #(
    .VSYNC_ACT (VSYNC_ACT)
  ) u_in_reg (
    .clk_i   (CMOS_PCLK),
    .rst_i   (cmos_rst),
    .vsync_i (CMOS_VSYNC),
    .href_i  (CMOS_HREF),
    .db_i    (CMOS_DB),
    .vsync_o (vs),
    .href_o  (href),
    .db_o    (db)
  );

  state_e         state_q, state_d;
  logic           vs_prev_q, href_prev_q;
  logic           phase_q, phase_d;
  logic [7:0]     hi_q, hi_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           pr_valid_q, pr_valid_d;
  rgb565_t        pr_data_q, pr_data_d;
  logic [X_W-1:0] pr_x_q, pr_x_d;
  logic [Y_W-1:0] pr_y_q, pr_y_d;
  logic           frame_done_q, frame_done_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic           line_err_q, line_err_d, line_err_set;
  logic           overflow_q, overflow_d, overflow_set;
  logic           in_win;
  logic           pix_valid_q, pix_valid_d;
  logic [15:0]    pix_data_q;
  logic [X_W-1:0] pix_x_q;
  logic [Y_W-1:0] pix_y_q;
  logic           pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    x_d          = x_q;
    y_d          = y_q;
    pr_valid_d   = 1'b0;
    pr_data_d    = pr_data_q;
    pr_x_d       = pr_x_q;
    pr_y_d       = pr_y_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_set = 1'b0;

    if (state_q != S_WAIT && !vs) begin
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + 8'd1;
      y_d          = '0;
      phase_d      = 1'b0;
      state_d      = S_WAIT;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (vs && !vs_prev_q && capture_en) begin
            y_d     = '0;
            state_d = S_FRAME;
          end
        end
        S_FRAME: begin
          // The rising-edge cycle already carries the first (high) byte.
          if (href && !href_prev_q) begin
            hi_d    = db;
            phase_d = 1'b1;
            x_d     = '0;
            state_d = S_LINE;
          end
        end
        S_LINE: begin
          if (href) begin
            if (!phase_q) begin
              hi_d    = db;
              phase_d = 1'b1;
            end else begin
              pr_valid_d = 1'b1;
              pr_data_d  = pack_rgb565(hi_q, db);
              pr_x_d     = x_q;
              pr_y_d     = y_q;
              x_d        = (x_q == '1) ? x_q : x_q + 1'b1;
              phase_d    = 1'b0;
            end
          end else begin
            line_err_set = phase_q;
            phase_d      = 1'b0;
            y_d          = (y_q == '1) ? y_q : y_q + 1'b1;
            state_d      = S_FRAME;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  // Output stage: crop to the image window and gate on FIFO space.
  always_comb begin
    in_win       = pr_valid_q && (32'(pr_x_q) < IMG_W) && (32'(pr_y_q) < IMG_H);
    pix_valid_d  = in_win && !pix_bus.fifo_full;
    overflow_set = in_win && pix_bus.fifo_full;
    pix_sof_d    = pix_valid_d && (pr_x_q == '0) && (pr_y_q == '0);
    pix_eol_d    = pix_valid_d && (32'(pr_x_q) == IMG_W - 1);
    overflow_d   = overflow_set || (overflow_q && !err_clr);
    line_err_d   = line_err_set || (line_err_q && !err_clr);
  end

  always_ff @(posedge CMOS_PCLK) begin
    if (cmos_rst) begin
      state_q      <= S_WAIT;
      vs_prev_q    <= 1'b1;
      href_prev_q  <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= 8'h00;
      x_q          <= '0;
      y_q          <= '0;
      pr_valid_q   <= 1'b0;
      pr_data_q    <= '0;
      pr_x_q       <= '0;
      pr_y_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
      line_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= 16'h0000;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs;
      href_prev_q  <= href;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pr_valid_q   <= pr_valid_d;
      pr_data_q    <= pr_data_d;
      pr_x_q       <= pr_x_d;
      pr_y_q       <= pr_y_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
      overflow_q   <= overflow_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pr_data_q;
      pix_x_q      <= pr_x_q;
      pix_y_q      <= pr_y_q;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
    end
  end

  assign pix_bus.pix_valid = pix_valid_q;
  assign pix_bus.pix_data  = pix_data_q;
  assign pix_bus.pix_x     = pix_x_q;
  assign pix_bus.pix_y     = pix_y_q;
  assign pix_bus.pix_sof   = pix_sof_q;
  assign pix_bus.pix_eol   = pix_eol_q;
  assign frame_done        = frame_done_q;
  assign frame_cnt         = frame_cnt_q;
  assign overflow          = overflow_q;
  assign line_err          = line_err_q;

endmodule

// File: tb/tb_ov5640_capture.sv
// Directed bench for ov5640_capture with a 4x2 window; pixels are logged by a monitor and checked.
module tb_ov5640_capture;
  import cmos_pkg::*;

  localparam int unsigned ImgW = 4;
  localparam int unsigned ImgH = 2;

  logic       clk = 1'b0;
  logic       cmos_rst, vsync, href, capture_en, err_clr;
  logic [7:0] db;
  logic       frame_done, overflow, line_err;
  logic [7:0] frame_cnt;

  ov5640_capture_if bus ();

  ov5640_capture #(
    .IMG_W     (ImgW),
    .IMG_H     (ImgH),
    .VSYNC_ACT (1'b1)
  ) dut (
    .CMOS_PCLK  (clk),
    .cmos_rst   (cmos_rst),
    .CMOS_VSYNC (vsync),
    .CMOS_HREF  (href),
    .CMOS_DB    (db),
    .capture_en (capture_en),
    .err_clr    (err_clr),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow),
    .line_err   (line_err),
    .pix_bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             e;
    logic [15:0]    d;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           sof;
    logic           eol;
  } pix_t;

  pix_t       got[$];
  logic [7:0] lb[$];
  int         be[$];
  int         edge_cnt = 0;
  int         fd_count = 0;
  int         fd_edge  = -1;
  int         stray    = 0;
  int         ff_tick  = -1;
  int         errors   = 0;
  int         checks   = 0;
  int         ev, k1, k3, l, p;

  // Monitor samples 1 time unit after each active edge.
  initial begin
    pix_t r;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (bus.pix_valid) begin
        r.e = edge_cnt; r.d = bus.pix_data; r.x = bus.pix_x; r.y = bus.pix_y;
        r.sof = bus.pix_sof; r.eol = bus.pix_eol;
        got.push_back(r);
      end else if (bus.pix_sof || bus.pix_eol) begin
        stray++;
      end
      if (frame_done) begin
        fd_count++;
        fd_edge = edge_cnt;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vsync = vs; href = 1'b0; db = 8'h00; bus.fifo_full = 1'b0;
    end
  endtask

  // Drives lb[] as one HREF-high line followed by two idle cycles.
  task automatic send_line();
    be.delete();
    for (int i = 0; i < lb.size() + 2; i++) begin
      @(negedge clk);
      vsync = 1'b1;
      if (i < lb.size()) begin
        href = 1'b1; db = lb[i];
      end else begin
        href = 1'b0; db = 8'h00;
      end
      bus.fifo_full = (i == ff_tick);
      be.push_back(edge_cnt + 1);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    cmos_rst = 1'b1; vsync = 1'b1; href = 1'b0; db = 8'h00;
    capture_en = 1'b1; err_clr = 1'b0; bus.fifo_full = 1'b0;
    idle(2, 1'b1);
    check_eq("rst_pix_valid", 32'(bus.pix_valid), 0);
    check_eq("rst_pix_data", 32'(bus.pix_data), 0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("rst_flags", 32'({frame_done, overflow, line_err, bus.pix_sof, bus.pix_eol}), 0);

    // Reset released in the middle of an active frame.
    lb = {8'h11, 8'h22, 8'h33, 8'h44};
    send_line();
    @(negedge clk); cmos_rst = 1'b0;
    send_line();
    send_line();
    idle(4, 1'b0);
    check_eq("midframe_no_pix", got.size(), 0);
    check_eq("midframe_no_done", fd_count, 0);
    check_eq("midframe_cnt", 32'(frame_cnt), 0);

    // First line F8,00,07,E0 with latency check.
    idle(3, 1'b1);
    lb = {8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line();
    k1 = be[1]; k3 = be[3];
    idle(4, 1'b0);
    check_eq("t2_count", got.size(), 2);
    check_eq("t2_p0_data", 32'(got[0].d), 'hF800);
    check_eq("t2_p0_xy", 32'({got[0].x, got[0].y}), 0);
    check_eq("t2_p0_sof", 32'(got[0].sof), 1);
    check_eq("t2_p0_lat", got[0].e, k1 + 2);
    check_eq("t2_p1_data", 32'(got[1].d), 'h07E0);
    check_eq("t2_p1_x", 32'(got[1].x), 1);
    check_eq("t2_p1_sof", 32'(got[1].sof), 0);
    check_eq("t2_p1_lat", got[1].e, k3 + 2);
    got.delete();

    // Three lines of six pixels into a 4x2 window.
    idle(3, 1'b1);
    for (int ln = 0; ln < 3; ln++) begin
      lb.delete();
      for (int px = 0; px < 6; px++) begin
        lb.push_back(8'(16 * ln + px));
        lb.push_back(8'(160 + px));
      end
      send_line();
    end
    idle(4, 1'b0);
    check_eq("t3_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      l = i / 4; p = i % 4;
      check_eq("t3_x", 32'(got[i].x), p);
      check_eq("t3_y", 32'(got[i].y), l);
      check_eq("t3_data", 32'(got[i].d), (16 * l + p) * 256 + 160 + p);
      check_eq("t3_eol", 32'(got[i].eol), (p == 3) ? 1 : 0);
      check_eq("t3_sof", 32'(got[i].sof), (i == 0) ? 1 : 0);
    end
    got.delete();

    // Odd byte count line.
    idle(3, 1'b1);
    lb = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_line();
    idle(2, 1'b1);
    check_eq("t4_count", got.size(), 3);
    check_eq("t4_last_data", 32'(got[2].d), 'h0506);
    check_eq("t4_line_err", 32'(line_err), 1);
    pulse_clr();
    check_eq("t4_line_err_clr", 32'(line_err), 0);
    idle(4, 1'b0);
    got.delete();

    // FIFO full during pixel x=1.
    idle(3, 1'b1);
    lb = {8'hA0, 8'h50, 8'hA1, 8'h51, 8'hA2, 8'h52, 8'hA3, 8'h53};
    ff_tick = 5;
    send_line();
    ff_tick = -1;
    idle(4, 1'b0);
    check_eq("t5_count", got.size(), 3);
    check_eq("t5_x0", 32'(got[0].x), 0);
    check_eq("t5_x2", 32'(got[1].x), 2);
    check_eq("t5_x3", 32'(got[2].x), 3);
    check_eq("t5_d2", 32'(got[1].d), 'hA252);
    check_eq("t5_eol3", 32'(got[2].eol), 1);
    check_eq("t5_overflow", 32'(overflow), 1);
    pulse_clr();
    check_eq("t5_overflow_clr", 32'(overflow), 0);
    got.delete();

    // Frame counting from a fresh reset; third frame with capture disabled.
    @(negedge clk); cmos_rst = 1'b1;
    idle(2, 1'b0);
    check_eq("t6_rst_cnt", 32'(frame_cnt), 0);
    @(negedge clk); cmos_rst = 1'b0;
    fd_count = 0;
    for (int f = 1; f <= 2; f++) begin
      idle(3, 1'b0);
      idle(3, 1'b1);
      lb = {8'h12, 8'h34, 8'h56, 8'h78};
      send_line();
      idle(2, 1'b1);
      @(negedge clk); vsync = 1'b0; ev = edge_cnt + 1;
      idle(3, 1'b0);
      check_eq("t6_done_count", fd_count, f);
      check_eq("t6_done_edge", fd_edge, ev + 1);
      check_eq("t6_frame_cnt", 32'(frame_cnt), f);
    end
    got.delete();
    capture_en = 1'b0;
    idle(3, 1'b0);
    idle(3, 1'b1);
    send_line();
    idle(4, 1'b0);
    check_eq("t6_dis_done", fd_count, 2);
    check_eq("t6_dis_cnt", 32'(frame_cnt), 2);
    check_eq("t6_dis_pix", got.size(), 0);
    check_eq("sof_eol_gated", stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
